alu_operand_loader: RTL

Input stage directly upstream of the ALU datapath and its bitwise gate submodules on the Basys 3 board. Debounces two push-buttons and synchronises the slide switches. Walks the user through loading operand A, operand B and the opcode from the switches. Presents the registered operand/opcode bundle to the ALU with a valid level and a one-cycle strobe.

---
 rtl/alu_operand_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - button/switch input stage that loads operands A, B and opcode for the ALU (optional debounce: ALU_LOADER_DEBOUNCE_EN)
module alu_operand_loader #(
    parameter int W         = 4,
    parameter int OPW       = 3,
    parameter int DB_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   sw,
    input  logic           btn_next,
    input  logic           btn_clr,
    output logic [W-1:0]   a,
    output logic [W-1:0]   b,
    output logic [OPW-1:0] op,
    output logic           operands_valid,
    output logic           load_strobe,
    output logic [1:0]     phase
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Reject parameter combinations the datapath cannot represent.
    if (OPW > W || OPW < 1) begin : g_bad_opw
        $error("alu_operand_loader: OPW must be in 1..W");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("alu_operand_loader: DB_CYCLES must be at least 1");
    end

    logic [W-1:0] sw_meta, sw_sync;
    logic         next_meta, next_sync, clr_meta, clr_sync;
    logic         next_stable, clr_stable;
    logic         next_stable_q, clr_stable_q;
    logic         next_p, clr_p;
    state_t       state, state_nx;
    logic         cap_a, cap_b, cap_op, drop_valid;

    // Two-flop synchronisers for every asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            next_meta <= 1'b0;
            next_sync <= 1'b0;
            clr_meta  <= 1'b0;
            clr_sync  <= 1'b0;
        end else begin
            sw_meta   <= sw;
            sw_sync   <= sw_meta;
            next_meta <= btn_next;
            next_sync <= next_meta;
            clr_meta  <= btn_clr;
            clr_sync  <= clr_meta;
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] next_cnt, clr_cnt;

    // Stable level follows the synced level only after it has differed for DB_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_cnt    <= '0;
            next_stable <= 1'b0;
            clr_cnt     <= '0;
            clr_stable  <= 1'b0;
        end else begin
            if (next_sync == next_stable) begin
                next_cnt <= '0;
            end else if (next_cnt == CNT_MAX) begin
                next_stable <= next_sync;
                next_cnt    <= '0;
            end else begin
                next_cnt <= next_cnt + 1'b1;
            end
            if (clr_sync == clr_stable) begin
                clr_cnt <= '0;
            end else if (clr_cnt == CNT_MAX) begin
                clr_stable <= clr_sync;
                clr_cnt    <= '0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end
`else
    // Inputs are trusted to be clean: the synced level is the stable level.
    assign next_stable = next_sync;
    assign clr_stable  = clr_sync;
`endif

    // Previous stable levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_stable_q <= 1'b0;
            clr_stable_q  <= 1'b0;
        end else begin
            next_stable_q <= next_stable;
            clr_stable_q  <= clr_stable;
        end
    end

    assign next_p = next_stable & ~next_stable_q;
    assign clr_p  = clr_stable & ~clr_stable_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD_A;
        else        state <= state_nx;
    end

    // Next state and capture enables; clear overrides a simultaneous advance.
    always_comb begin
        state_nx   = state;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        cap_op     = 1'b0;
        drop_valid = 1'b0;
        if (clr_p) begin
            state_nx = LOAD_A;
        end else if (next_p) begin
            unique case (state)
                LOAD_A:  begin cap_a  = 1'b1;      state_nx = LOAD_B;  end
                LOAD_B:  begin cap_b  = 1'b1;      state_nx = LOAD_OP; end
                LOAD_OP: begin cap_op = 1'b1;      state_nx = DONE;    end
                DONE:    begin drop_valid = 1'b1;  state_nx = LOAD_A;  end
                default: state_nx = LOAD_A;
            endcase
        end
    end

    // Operand registers, valid level and one-cycle strobe on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a              <= '0;
            b              <= '0;
            op             <= '0;
            operands_valid <= 1'b0;
            load_strobe    <= 1'b0;
        end else begin
            load_strobe <= cap_op;
            if (clr_p) begin
                a              <= '0;
                b              <= '0;
                op             <= '0;
                operands_valid <= 1'b0;
            end else begin
                if (cap_a)      a  <= sw_sync;
                if (cap_b)      b  <= sw_sync;
                if (cap_op)     op <= sw_sync[OPW-1:0];
                if (cap_op)     operands_valid <= 1'b1;
                if (drop_valid) operands_valid <= 1'b0;
            end
        end
    end

    assign phase = state;

endmodule
